// File: rtl/multicycle_controller.sv
// Multi-cycle sequencer for the MIPS subset (add/addu, sub/subu, ori, lw, sw, beq, lui).
// Steps the shared datapath through fetch/decode/execute/memory/write-back with a memory-ready handshake.
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               IMemRd,
  output logic               IRWr,
  output logic               PCWr,
  output logic               nPC_sel,
  output logic               RegWr,
  output logic               RegDst,
  output logic [1:0]         ExtOp,
  output logic               ALUSrc,
  output logic [2:0]         ALUctr,
  output logic               MemRd,
  output logic               MemWr,
  output logic               MemtoReg,
  output logic               retire,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = STATE_W'(0),
    S_DECODE   = STATE_W'(1),
    S_EXEC     = STATE_W'(2),
    S_WB_ALU   = STATE_W'(3),
    S_MEM_ADDR = STATE_W'(4),
    S_MEM_RD   = STATE_W'(5),
    S_WB_MEM   = STATE_W'(6),
    S_MEM_WR   = STATE_W'(7),
    S_BRANCH   = STATE_W'(8)
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] F_ADD    = 6'h20;
  localparam logic [5:0] F_ADDU   = 6'h21;
  localparam logic [5:0] F_SUB    = 6'h22;
  localparam logic [5:0] F_SUBU   = 6'h23;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_LUI = 3'b111;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  state_t r_state;
  state_t w_next;

  logic       w_r_add, w_r_sub, w_rtype, w_ori, w_lui, w_lw, w_sw, w_beq, w_alu_cls;
  logic [2:0] w_alu_op;
  logic       w_alu_src;
  logic [1:0] w_alu_ext;

  logic       w_imemrd, w_irwr, w_pcwr, w_npc_sel, w_regwr, w_regdst;
  logic [1:0] w_extop;
  logic       w_alusrc;
  logic [2:0] w_aluctr;
  logic       w_memrd, w_memwr, w_memtoreg, w_retire, w_illegal;

  assign w_r_add   = (opcode == OP_RTYPE) && ((funct == F_ADD) || (funct == F_ADDU));
  assign w_r_sub   = (opcode == OP_RTYPE) && ((funct == F_SUB) || (funct == F_SUBU));
  assign w_rtype   = w_r_add || w_r_sub;
  assign w_ori     = (opcode == OP_ORI);
  assign w_lui     = (opcode == OP_LUI);
  assign w_lw      = (opcode == OP_LW);
  assign w_sw      = (opcode == OP_SW);
  assign w_beq     = (opcode == OP_BEQ);
  assign w_alu_cls = w_rtype || w_ori || w_lui;

  // ALU setup shared by EXEC and WB_ALU so the result stays stable through write-back
  always_comb begin
    w_alu_op  = ALU_ADD;
    w_alu_src = 1'b0;
    w_alu_ext = EXT_ZERO;
    if (w_r_sub) begin
      w_alu_op = ALU_SUB;
    end else if (w_ori) begin
      w_alu_op  = ALU_OR;
      w_alu_src = 1'b1;
    end else if (w_lui) begin
      w_alu_op  = ALU_LUI;
      w_alu_src = 1'b1;
      w_alu_ext = EXT_LUI;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = S_FETCH;
    w_imemrd   = 1'b0;
    w_irwr     = 1'b0;
    w_pcwr     = 1'b0;
    w_npc_sel  = 1'b0;
    w_regwr    = 1'b0;
    w_regdst   = 1'b0;
    w_extop    = EXT_ZERO;
    w_alusrc   = 1'b0;
    w_aluctr   = ALU_ADD;
    w_memrd    = 1'b0;
    w_memwr    = 1'b0;
    w_memtoreg = 1'b0;
    w_retire   = 1'b0;
    w_illegal  = 1'b0;

    case (r_state)
      S_FETCH: begin
        w_imemrd = 1'b1;
        if (mem_ready) begin
          w_irwr = 1'b1;
          w_pcwr = 1'b1;
          w_next = S_DECODE;
        end else begin
          w_next = S_FETCH;
        end
      end

      S_DECODE: begin
        if (w_alu_cls) begin
          w_next = S_EXEC;
        end else if (w_lw || w_sw) begin
          w_next = S_MEM_ADDR;
        end else if (w_beq) begin
          w_next = S_BRANCH;
        end else begin
          w_illegal = 1'b1;
          w_next    = S_FETCH;
        end
      end

      S_EXEC: begin
        w_aluctr = w_alu_op;
        w_alusrc = w_alu_src;
        w_extop  = w_alu_ext;
        w_next   = S_WB_ALU;
      end

      S_WB_ALU: begin
        w_aluctr = w_alu_op;
        w_alusrc = w_alu_src;
        w_extop  = w_alu_ext;
        w_regwr  = 1'b1;
        w_regdst = w_rtype;
        w_retire = 1'b1;
        w_next   = S_FETCH;
      end

      S_MEM_ADDR: begin
        w_aluctr = ALU_ADD;
        w_alusrc = 1'b1;
        w_extop  = EXT_SIGN;
        w_next   = w_sw ? S_MEM_WR : S_MEM_RD;
      end

      S_MEM_RD: begin
        w_aluctr = ALU_ADD;
        w_alusrc = 1'b1;
        w_extop  = EXT_SIGN;
        w_memrd  = 1'b1;
        w_next   = mem_ready ? S_WB_MEM : S_MEM_RD;
      end

      // Sign extension is kept on so the address path does not glitch during write-back
      S_WB_MEM: begin
        w_extop    = EXT_SIGN;
        w_regwr    = 1'b1;
        w_memtoreg = 1'b1;
        w_retire   = 1'b1;
        w_next     = S_FETCH;
      end

      S_MEM_WR: begin
        w_aluctr = ALU_ADD;
        w_alusrc = 1'b1;
        w_extop  = EXT_SIGN;
        w_memwr  = 1'b1;
        if (mem_ready) begin
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end else begin
          w_next = S_MEM_WR;
        end
      end

      S_BRANCH: begin
        w_aluctr  = ALU_SUB;
        w_extop   = EXT_SIGN;
        w_retire  = 1'b1;
        w_pcwr    = zero;
        w_npc_sel = zero;
        w_next    = S_FETCH;
      end

      default: w_next = S_FETCH;
    endcase
  end

  // Reset holds every output low, independent of the registered state
  assign IMemRd   = rst_n & w_imemrd;
  assign IRWr     = rst_n & w_irwr;
  assign PCWr     = rst_n & w_pcwr;
  assign nPC_sel  = rst_n & w_npc_sel;
  assign RegWr    = rst_n & w_regwr;
  assign RegDst   = rst_n & w_regdst;
  assign ExtOp    = rst_n ? w_extop : 2'b00;
  assign ALUSrc   = rst_n & w_alusrc;
  assign ALUctr   = rst_n ? w_aluctr : 3'b000;
  assign MemRd    = rst_n & w_memrd;
  assign MemWr    = rst_n & w_memwr;
  assign MemtoReg = rst_n & w_memtoreg;
  assign retire   = rst_n & w_retire;
  assign illegal  = rst_n & w_illegal;
  assign state    = rst_n ? r_state : '0;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: an instruction-level model pushes the expected
// per-cycle control vector; a negedge monitor pops and compares against the DUT outputs.
module tb_multicycle_controller;

  typedef struct packed {
    logic [3:0] st;
    logic       imemrd, irwr, pcwr, npc, regwr, regdst;
    logic [1:0] extop;
    logic       alusrc;
    logic [2:0] aluctr;
    logic       memrd, memwr, memtoreg, retire, illegal;
  } ov_t;

  localparam int C_ILL = 0, C_ADD = 1, C_SUB = 2, C_ORI = 3, C_LUI = 4,
                 C_LW = 5, C_SW = 6, C_BEQ = 7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic       zero = 1'b0, mem_ready = 1'b0;
  logic       IMemRd, IRWr, PCWr, nPC_sel, RegWr, RegDst, ALUSrc;
  logic       MemRd, MemWr, MemtoReg, retire, illegal;
  logic [1:0] ExtOp;
  logic [2:0] ALUctr;
  logic [3:0] state;

  ov_t q[$];
  ov_t mon_e, mon_a;
  int  checks = 0, errors = 0, cyc_no = 0;
  int  exp_retire = 0, got_retire = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .IMemRd(IMemRd), .IRWr(IRWr), .PCWr(PCWr),
    .nPC_sel(nPC_sel), .RegWr(RegWr), .RegDst(RegDst), .ExtOp(ExtOp),
    .ALUSrc(ALUSrc), .ALUctr(ALUctr), .MemRd(MemRd), .MemWr(MemWr),
    .MemtoReg(MemtoReg), .retire(retire), .illegal(illegal), .state(state)
  );

  function automatic ov_t dflt(input logic [3:0] st);
    ov_t o;
    o = '0;
    o.st = st;
    o.aluctr = 3'b010;
    return o;
  endfunction

  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: begin
        if (fn == 6'h20 || fn == 6'h21) return C_ADD;
        if (fn == 6'h22 || fn == 6'h23) return C_SUB;
        return C_ILL;
      end
      6'h0D: return C_ORI;
      6'h0F: return C_LUI;
      6'h23: return C_LW;
      6'h2B: return C_SW;
      6'h04: return C_BEQ;
      default: return C_ILL;
    endcase
  endfunction

  // One clock cycle of stimulus plus the control vector expected during it
  task automatic cyc(input logic [5:0] op, input logic [5:0] fn, input logic mr,
                     input logic z, input logic rn, input ov_t e);
    @(posedge clk);
    #1;
    opcode = op; funct = fn; mem_ready = mr; zero = z; rst_n = rn;
    q.push_back(e);
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic do_instr(input logic [5:0] op, input logic [5:0] fn,
                          input int fw, input int mw, input logic z);
    ov_t e, a;
    int c;
    c = classify(op, fn);
    for (int i = 0; i < fw; i++) begin
      e = dflt(4'd0); e.imemrd = 1'b1;
      cyc(op, fn, 1'b0, rb(), 1'b1, e);
    end
    e = dflt(4'd0); e.imemrd = 1'b1; e.irwr = 1'b1; e.pcwr = 1'b1;
    cyc(op, fn, 1'b1, rb(), 1'b1, e);
    e = dflt(4'd1); e.illegal = (c == C_ILL);
    cyc(op, fn, rb(), rb(), 1'b1, e);
    a = dflt(4'd4); a.alusrc = 1'b1; a.extop = 2'b01;
    case (c)
      C_ADD, C_SUB, C_ORI, C_LUI: begin
        e = dflt(4'd2);
        e.aluctr = (c == C_SUB) ? 3'b110 : (c == C_ORI) ? 3'b001 : (c == C_LUI) ? 3'b111 : 3'b010;
        e.alusrc = (c == C_ORI || c == C_LUI);
        e.extop  = (c == C_LUI) ? 2'b10 : 2'b00;
        cyc(op, fn, rb(), rb(), 1'b1, e);
        e.st = 4'd3; e.regwr = 1'b1; e.retire = 1'b1; e.regdst = (c == C_ADD || c == C_SUB);
        cyc(op, fn, rb(), rb(), 1'b1, e);
      end
      C_LW: begin
        cyc(op, fn, rb(), rb(), 1'b1, a);
        e = a; e.st = 4'd5; e.memrd = 1'b1;
        for (int i = 0; i < mw; i++) cyc(op, fn, 1'b0, rb(), 1'b1, e);
        cyc(op, fn, 1'b1, rb(), 1'b1, e);
        e = dflt(4'd6); e.regwr = 1'b1; e.memtoreg = 1'b1; e.retire = 1'b1; e.extop = 2'b01;
        cyc(op, fn, rb(), rb(), 1'b1, e);
      end
      C_SW: begin
        cyc(op, fn, rb(), rb(), 1'b1, a);
        e = a; e.st = 4'd7; e.memwr = 1'b1;
        for (int i = 0; i < mw; i++) cyc(op, fn, 1'b0, rb(), 1'b1, e);
        e.retire = 1'b1;
        cyc(op, fn, 1'b1, rb(), 1'b1, e);
      end
      C_BEQ: begin
        e = dflt(4'd8); e.aluctr = 3'b110; e.extop = 2'b01; e.retire = 1'b1;
        e.pcwr = z; e.npc = z;
        cyc(op, fn, rb(), z, 1'b1, e);
      end
      default: ;
    endcase
    if (c != C_ILL) exp_retire++;
  endtask

  always @(negedge clk) begin
    cyc_no++;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      mon_a = {state, IMemRd, IRWr, PCWr, nPC_sel, RegWr, RegDst, ExtOp, ALUSrc, ALUctr,
               MemRd, MemWr, MemtoReg, retire, illegal};
      checks++;
      if (mon_a !== mon_e) begin
        errors++;
        $display("FAIL outputs cycle %0d: got state=%0d vec=%h, exp state=%0d vec=%h",
                 cyc_no, mon_a.st, mon_a, mon_e.st, mon_e);
      end
    end
    if (retire === 1'b1) got_retire++;
  end

  logic [5:0] op_tab [10];
  logic [5:0] fn_tab [6];
  ov_t e0;

  initial begin
    op_tab = '{6'h00, 6'h00, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h3F, 6'h08, 6'h00};
    fn_tab = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h2A};

    cyc(6'h00, 6'h00, 1'b1, 1'b0, 1'b0, ov_t'('0));
    cyc(6'h00, 6'h00, 1'b1, 1'b0, 1'b0, ov_t'('0));

    do_instr(6'h00, 6'h21, 0, 0, 1'b0);
    do_instr(6'h23, 6'h00, 1, 2, 1'b0);
    do_instr(6'h04, 6'h00, 0, 0, 1'b1);
    do_instr(6'h04, 6'h00, 0, 0, 1'b0);
    do_instr(6'h3F, 6'h00, 0, 0, 1'b0);
    do_instr(6'h00, 6'h24, 0, 0, 1'b0);
    do_instr(6'h0F, 6'h00, 0, 0, 1'b0);
    do_instr(6'h2B, 6'h00, 0, 2, 1'b0);
    do_instr(6'h00, 6'h22, 2, 0, 1'b0);
    do_instr(6'h0D, 6'h00, 0, 0, 1'b0);

    // reset in the middle of a load that is waiting on memory
    e0 = dflt(4'd0); e0.imemrd = 1'b1; e0.irwr = 1'b1; e0.pcwr = 1'b1;
    cyc(6'h23, 6'h00, 1'b1, 1'b0, 1'b1, e0);
    cyc(6'h23, 6'h00, 1'b0, 1'b0, 1'b1, dflt(4'd1));
    e0 = dflt(4'd4); e0.alusrc = 1'b1; e0.extop = 2'b01;
    cyc(6'h23, 6'h00, 1'b0, 1'b0, 1'b1, e0);
    e0.st = 4'd5; e0.memrd = 1'b1;
    cyc(6'h23, 6'h00, 1'b0, 1'b0, 1'b1, e0);
    cyc(6'h23, 6'h00, 1'b1, 1'b0, 1'b0, ov_t'('0));
    do_instr(6'h04, 6'h00, 1, 0, 1'b0);

    for (int n = 0; n < 80; n++) begin
      do_instr(op_tab[$urandom_range(0, 9)], fn_tab[$urandom_range(0, 5)],
               $urandom_range(0, 2), $urandom_range(0, 2), rb());
    end

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, exp 0", q.size());
    end
    checks++;
    if (got_retire != exp_retire) begin
      errors++;
      $display("FAIL retire_count: got %0d exp %0d", got_retire, exp_retire);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
